if_fetch: RTL and testbench

//  Instruction-fetch stage. Owns the PC, drives the instruction memory through a
//  req/ack handshake, and presents {if_pc, if_inst, if_valid} to the IF/ID

---
 rtl/if_fetch.sv | 186 ++++++++++++++++++
 tb/tb_if_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives imem over a req/ack handshake and
// presents {if_pc, if_inst, if_valid} to IF/ID, with a one-entry skid and branch redirect.
module if_fetch #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
  logic [DATA_W-1:0]   out_inst_q, out_inst_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0]   skid_inst_q, skid_inst_d;
  logic                skid_valid_q, skid_valid_d;
  logic                discard_q, discard_d;

  logic                xfer;
  logic                redirect;
  logic [ADDR_W-1:0]   addr_inc;

  assign xfer     = req_q && imem_ack;
  assign redirect = branch_flag && !stall;
  assign addr_inc = addr_q + ADDR_W'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    out_valid_d  = out_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_valid_d = skid_valid_q;
    discard_d    = discard_q;

    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d         = branch_target;
          skid_valid_d = 1'b0;
          out_inst_d   = '0;
          out_valid_d  = 1'b0;
        end else if (!stall) begin
          req_d       = 1'b1;
          addr_d      = pc_q;
          state_d     = BUSY;
          out_inst_d  = '0;
          out_valid_d = 1'b0;
        end
      end

      BUSY: begin
        if (xfer) begin
          if (discard_q || redirect) begin
            // Wrong-path data: pc already holds (or now takes) the redirect target,
            // so it is not advanced past the dropped address.
            discard_d = 1'b0;
            if (redirect) begin
              pc_d         = branch_target;
              skid_valid_d = 1'b0;
            end
            if (!stall) begin
              req_d       = 1'b1;
              addr_d      = redirect ? branch_target : pc_q;
              out_inst_d  = '0;
              out_valid_d = 1'b0;
            end else begin
              req_d   = 1'b0;
              state_d = IDLE;
            end
          end else if (!stall) begin
            pc_d        = addr_inc;
            out_pc_d    = addr_q;
            out_inst_d  = imem_rdata;
            out_valid_d = 1'b1;
            req_d       = 1'b1;
            addr_d      = addr_inc;
          end else begin
            pc_d         = addr_inc;
            skid_pc_d    = addr_q;
            skid_inst_d  = imem_rdata;
            skid_valid_d = 1'b1;
            req_d        = 1'b0;
            state_d      = HOLD;
          end
        end else if (redirect) begin
          discard_d    = 1'b1;
          pc_d         = branch_target;
          skid_valid_d = 1'b0;
          out_inst_d   = '0;
          out_valid_d  = 1'b0;
        end else if (!stall) begin
          out_inst_d  = '0;
          out_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d         = branch_target;
          skid_valid_d = 1'b0;
          out_inst_d   = '0;
          out_valid_d  = 1'b0;
          state_d      = IDLE;
        end else if (!stall) begin
          if (skid_valid_q) begin
            out_pc_d    = skid_pc_q;
            out_inst_d  = skid_inst_q;
            out_valid_d = 1'b1;
          end else begin
            out_inst_d  = '0;
            out_valid_d = 1'b0;
          end
          skid_valid_d = 1'b0;
          req_d        = 1'b1;
          addr_d       = pc_q;
          state_d      = BUSY;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= '0;
      out_pc_q     <= '0;
      out_inst_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
      skid_valid_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      out_valid_q  <= out_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_valid_q <= skid_valid_d;
      discard_q    <= discard_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_pc     = out_pc_q;
  assign if_inst   = out_inst_q;
  assign if_valid  = out_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: latency-programmable memory with mem[a]=a^0xA5,
// and a scoreboard of expected PCs consumed by IF/ID.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int unsigned lat;
  int unsigned wcnt;
  logic        mon_en;
  logic [31:0] sb[$];
  int          n_tests;
  int          n_fail;

  if_fetch #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks once a request has waited lat cycles; lat=0 is zero-wait.
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_addr ^ 32'hA5;

  always @(posedge clk) begin
    if (rst)                       wcnt <= 0;
    else if (imem_req && imem_ack) wcnt <= 0;
    else if (imem_req)             wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // IF/ID consumes the presented instruction at every edge with stall=0.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (!if_valid) begin
        check("bubble_inst", if_inst, 64'h0);
      end else if (!stall) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", {32'h0, if_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          check("sb_pc", if_pc, e);
          check("sb_inst", if_inst, e ^ 32'hA5);
        end
      end
    end
  end

  task automatic push_run(input logic [31:0] start, input int count);
    for (int i = 0; i < count; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_pc", if_pc, 0);
    check("rst_inst", if_inst, 0);
    check("rst_valid", if_valid, 0);
    rst = 1'b0;
  endtask

  task automatic wait_addr(input logic [31:0] a, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (imem_req && imem_addr == a) found = 1'b1;
    end
    check(tag, found, 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, sb.size(), 0);
    mon_en = 1'b0;
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit found;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    stall = 1'b0;
    branch_flag = 1'b0;
    branch_target = '0;
    lat = 0;
    mon_en = 1'b0;

    // 1: zero-wait back-to-back fetch
    lat = 0;
    do_reset();
    push_run(32'h0, 8);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t1_req", imem_req, 1);
      check("t1_addr", imem_addr, 32'(4 * i));
      if (i > 0) begin
        check("t1_pc", if_pc, 32'(4 * (i - 1)));
        check("t1_valid", if_valid, 1);
      end
    end
    drain("t1_drain");

    // 2: latency 3 -> one valid in four
    lat = 3;
    do_reset();
    push_run(32'h0, 4);
    mon_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (if_valid) found = 1'b1;
    end
    check("t2_first_valid", found, 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cnt += int'(if_valid);
      @(posedge clk);
      #1;
    end
    check("t2_valid_count", cnt, 4);
    drain("t2_drain");

    // 3: stall with outstanding request, ack arrives in stall cycle 2
    lat = 1;
    do_reset();
    push_run(32'h0, 6);
    mon_en = 1'b1;
    wait_addr(32'h10, "t3_wait_0x10");
    stall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      check("t3_stall_req", imem_req, k <= 2);
      check("t3_stall_pc", if_pc, 32'hC);
      check("t3_stall_valid", if_valid, 1);
      check("t3_stall_inst", if_inst, 32'hC ^ 32'hA5);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    check("t3_release_pc", if_pc, 32'h10);
    check("t3_release_valid", if_valid, 1);
    drain("t3_drain");

    // 4: branch while 0x24 outstanding (latency 2)
    lat = 2;
    do_reset();
    push_run(32'h0, 9);
    push_run(32'h200, 2);
    mon_en = 1'b1;
    wait_addr(32'h24, "t4_wait_0x24");
    branch_flag = 1'b1;
    branch_target = 32'h200;
    @(posedge clk);
    #1;
    branch_flag = 1'b0;
    drain("t4_drain");

    // 5: branch coinciding with transfer of 0x30
    lat = 1;
    do_reset();
    push_run(32'h0, 12);
    push_run(32'h300, 2);
    mon_en = 1'b1;
    wait_addr(32'h30, "t5_wait_0x30");
    @(posedge clk);
    #1;
    branch_flag = 1'b1;
    branch_target = 32'h300;
    @(posedge clk);
    #1;
    branch_flag = 1'b0;
    check("t5_redirect_req", imem_req, 1);
    check("t5_redirect_addr", imem_addr, 32'h300);
    drain("t5_drain");

    // 6a: reset in the middle of BUSY
    lat = 2;
    do_reset();
    wait_addr(32'h8, "t6_wait_0x8");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_rst_req", imem_req, 0);
    check("t6_rst_addr", imem_addr, 0);
    check("t6_rst_pc", if_pc, 0);
    check("t6_rst_inst", if_inst, 0);
    check("t6_rst_valid", if_valid, 0);
    @(posedge clk);
    #1;
    check("t6_first_req", imem_req, 1);
    check("t6_first_addr", imem_addr, 32'h0);

    // 6b: PC wraps modulo 2^32
    lat = 0;
    do_reset();
    push_run(32'h0, 4);
    push_run(32'hFFFF_FFF8, 4);
    mon_en = 1'b1;
    wait_addr(32'h10, "t6_wait_0x10");
    branch_flag = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    @(posedge clk);
    #1;
    branch_flag = 1'b0;
    check("t6_wrap_a0", imem_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    check("t6_wrap_a1", imem_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    check("t6_wrap_a2", imem_addr, 32'h0);
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
